instr_fetch: RTL and testbench

Instruction fetch/issue unit for the snake CPU: owns the program counter, reads 16-bit instruction words from instruction memory over a req/ack handshake, and presents the decoded opcode and operand fields to `control`. It is the producer end of the `control` interface: it supplies `opcode` and instruction fields, and consumes `control`'s `c_pc_inc` / `c_pc_load` outputs, plus an end-of-instruction strobe, to advance or redirect the PC.

---
 rtl/snake_pkg.sv | 47 ++++
 rtl/prefetch_buf.sv | 31 +++
 rtl/instr_fetch.sv | 206 ++++++++++++++++++++
 tb/tb_instr_fetch.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg -- shared definitions for the snake CPU front end.
//   opcode_e       : 4-bit opcode encoding carried in IR[15:12]
//   *_HI / *_LO    : bit positions of the fixed 16-bit instruction fields
//   fetch_state_e  : instruction fetch FSM states
//   next_addr()    : PC increment, wrapping modulo 2^ADDR_W
package snake_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_ADDI = 4'd2,
    OP_ROW  = 4'd3,
    OP_COL  = 4'd4,
    OP_INCL = 4'd5,
    OP_F    = 4'd6,
    OP_LD   = 4'd7,
    OP_ST   = 4'd8,
    OP_JE   = 4'd9,
    OP_JNE  = 4'd10,
    OP_J    = 4'd11,
    OP_LDI  = 4'd12,
    OP_LFSR = 4'd13
  } opcode_e;

  // rb and imm deliberately overlap: rb is the high nibble of imm.
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 8;
  localparam int RB_HI  = 7;
  localparam int RB_LO  = 4;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // DRAIN is only reachable when the prefetch buffer is built in.
  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    FETCH      = 2'd1,
    ISSUE      = 2'd2,
    DRAIN      = 2'd3
  } fetch_state_e;

  function automatic logic [7:0] next_addr(input logic [7:0] a);
    return a + 8'd1;
  endfunction

endpackage

// File: rtl/prefetch_buf.sv
// prefetch_buf -- single-entry instruction holding register.
//   clk, rst_n : clock, async active-low reset
//   load       : capture d and mark valid (wins over clear)
//   clear      : invalidate the entry
//   d          : word to capture
//   vld, q     : entry valid flag and stored word
module prefetch_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end else if (clear) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch -- program counter owner and instruction fetch/issue unit.
//   Optional feature macro: INSTR_FETCH_PREFETCH_EN (one-entry prefetch of PC+1,
//   adds the DRAIN state). Default build fetches one instruction at a time.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   imem_req/addr           fetch request; addr stable while req high
//   imem_ack/rdata          single-cycle ack with data in the same cycle
//   instr_valid             IR holds an instruction to execute
//   opcode/ra/rb/imm        IR fields; imm is also the jump target
//   pc                      address of the instruction in IR
//   exec_done               last cycle of the current instruction
//   c_pc_inc / c_pc_load    PC update request from control (load wins)
module instr_fetch
  import snake_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [3:0]         opcode,
  output logic [3:0]         ra,
  output logic [3:0]         rb,
  output logic [7:0]         imm,
  output logic [ADDR_W-1:0]  pc,
  input  logic               exec_done,
  input  logic               c_pc_inc,
  input  logic               c_pc_load
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                vld_q, vld_d;

  logic                ack_ok;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   jmp_tgt;
  logic [ADDR_W-1:0]   nxt_pc;

  // An ack only counts against an outstanding request.
  assign ack_ok  = imem_ack & req_q;
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign jmp_tgt = ADDR_W'(ir_q[IMM_HI:IMM_LO]);

`ifdef INSTR_FETCH_PREFETCH_EN
  logic               buf_load, buf_clear, buf_vld;
  logic [INSTR_W-1:0] buf_q;
  logic [ADDR_W-1:0]  pc_inc2;

  assign pc_inc2 = pc_inc + ADDR_W'(1);

  prefetch_buf #(.W(INSTR_W)) u_pbuf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load),
    .clear (buf_clear),
    .d     (imem_rdata),
    .vld   (buf_vld),
    .q     (buf_q)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_WAIT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    addr_d  = addr_q;
    vld_d   = vld_q;
    nxt_pc  = pc_q;
`ifdef INSTR_FETCH_PREFETCH_EN
    buf_load  = 1'b0;
    buf_clear = 1'b0;
`endif

    case (state_q)
      RESET_WAIT: begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end

      FETCH: begin
        if (ack_ok) begin
          ir_d    = imem_rdata;
          req_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = ISSUE;
        end else if (!req_q) begin
          // Entered from DRAIN: the old request just finished, start ours.
          req_d  = 1'b1;
          addr_d = pc_q;
        end
      end

      ISSUE: begin
`ifdef INSTR_FETCH_PREFETCH_EN
        if (exec_done) begin
          if (c_pc_load || !c_pc_inc) begin
            // Redirect or hold: whatever was prefetched is for the wrong PC.
            nxt_pc    = c_pc_load ? jmp_tgt : pc_q;
            pc_d      = nxt_pc;
            vld_d     = 1'b0;
            buf_clear = 1'b1;
            if (req_q && !imem_ack) begin
              state_d = DRAIN;
            end else begin
              state_d = FETCH;
              req_d   = 1'b1;
              addr_d  = nxt_pc;
            end
          end else begin
            pc_d = pc_inc;
            if (buf_vld) begin
              ir_d      = buf_q;
              buf_clear = 1'b1;
              req_d     = 1'b1;
              addr_d    = pc_inc2;
            end else if (ack_ok) begin
              // Prefetch lands on the very cycle it is needed.
              ir_d   = imem_rdata;
              req_d  = 1'b1;
              addr_d = pc_inc2;
            end else if (req_q) begin
              // Outstanding request is already for the new PC; keep it.
              state_d = FETCH;
              vld_d   = 1'b0;
            end else begin
              state_d = FETCH;
              vld_d   = 1'b0;
              req_d   = 1'b1;
              addr_d  = pc_inc;
            end
          end
        end else if (ack_ok) begin
          buf_load = 1'b1;
          req_d    = 1'b0;
        end else if (!buf_vld && !req_q) begin
          req_d  = 1'b1;
          addr_d = pc_inc;
        end
`else
        if (exec_done) begin
          if (c_pc_load)     nxt_pc = jmp_tgt;
          else if (c_pc_inc) nxt_pc = pc_inc;
          else               nxt_pc = pc_q;
          pc_d    = nxt_pc;
          vld_d   = 1'b0;
          req_d   = 1'b1;
          addr_d  = nxt_pc;
          state_d = FETCH;
        end
`endif
      end

`ifdef INSTR_FETCH_PREFETCH_EN
      DRAIN: begin
        // Swallow the stale word, then refetch at the new PC.
        if (ack_ok) begin
          req_d   = 1'b0;
          state_d = FETCH;
        end
      end
`endif

      default: state_d = RESET_WAIT;
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = vld_q;
  assign opcode      = ir_q[OPC_HI:OPC_LO];
  assign ra          = ir_q[RA_HI:RA_LO];
  assign rb          = ir_q[RB_HI:RB_LO];
  assign imm         = ir_q[IMM_HI:IMM_LO];
  assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch -- directed bench for instr_fetch with a simple memory
// responder (configurable wait states, forced stray acks).
module tb_instr_fetch;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [3:0]         opcode, ra, rb;
  logic [7:0]         imm;
  logic [ADDR_W-1:0]  pc;
  logic               exec_done = 1'b0;
  logic               c_pc_inc = 1'b0;
  logic               c_pc_load = 1'b0;

  logic [15:0] mem [256];
  int          wait_n = 0;
  logic        ack_force = 1'b0;
  int          cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .opcode(opcode), .ra(ra), .rb(rb), .imm(imm),
    .pc(pc), .exec_done(exec_done), .c_pc_inc(c_pc_inc), .c_pc_load(c_pc_load)
  );

  // Memory: acks once the request has been up for wait_n cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= 0;
    else if (!imem_req || imem_ack) cnt <= 0;
    else                           cnt <= cnt + 1;
  end
  assign imem_ack   = (imem_req && cnt >= wait_n) || ack_force;
  assign imem_rdata = mem[imem_addr];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse(input logic inc, input logic load);
    exec_done = 1'b1; c_pc_inc = inc; c_pc_load = load;
    step();
    exec_done = 1'b0; c_pc_inc = 1'b0; c_pc_load = 1'b0;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0; exec_done = 1'b0; c_pc_inc = 1'b0; c_pc_load = 1'b0;
    ack_force = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    hold_reset();
    checks++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_ctl: got req/valid %b exp 00", {imem_req, instr_valid});
    end
    checks++;
    if (imem_addr !== 8'h00 || pc !== 8'h00) begin
      errors++; $display("FAIL reset_pc: got addr %h pc %h exp 00 00", imem_addr, pc);
    end
    checks++;
    if ({opcode, ra, rb, imm} !== 20'h0) begin
      errors++; $display("FAIL reset_ir: got %h exp 00000", {opcode, ra, rb, imm});
    end
  endtask

`ifndef INSTR_FETCH_PREFETCH_EN
  task automatic test_first_fetch();
    mem[0] = 16'h2A05; wait_n = 0;
    rst_n = 1'b1;
    step();
    checks++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, 8'h00}) begin
      errors++; $display("FAIL first_req: got req %b valid %b addr %h exp 1 0 00", imem_req, instr_valid, imem_addr);
    end
    step();
    checks++;
    if ({instr_valid, opcode, ra, rb, imm, pc} !== {1'b1, 4'h2, 4'hA, 4'h0, 8'h05, 8'h00}) begin
      errors++; $display("FAIL first_issue: got v%b op%h ra%h rb%h imm%h pc%h exp v1 op2 raA rb0 imm05 pc00",
                         instr_valid, opcode, ra, rb, imm, pc);
    end
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL first_req_drop: got %b exp 0", imem_req);
    end
  endtask

  task automatic test_inc();
    mem[1] = 16'h0110;
    pulse(1'b1, 1'b0);
    checks++;
    if ({instr_valid, imem_req, imem_addr} !== {2'b01, 8'h01}) begin
      errors++; $display("FAIL inc_fetch: got v%b req%b addr %h exp v0 req1 addr 01", instr_valid, imem_req, imem_addr);
    end
    step();
    checks++;
    if ({instr_valid, pc, opcode, ra, imm} !== {1'b1, 8'h01, 4'h0, 4'h1, 8'h10}) begin
      errors++; $display("FAIL inc_issue: got v%b pc%h op%h ra%h imm%h exp v1 pc01 op0 ra1 imm10",
                         instr_valid, pc, opcode, ra, imm);
    end
  endtask

  // Controls and stray acks must not disturb ISSUE without exec_done.
  task automatic test_ignored();
    mem[1] = 16'hFFFF;
    c_pc_inc = 1'b1; c_pc_load = 1'b1; ack_force = 1'b1;
    step(); step(); step();
    c_pc_inc = 1'b0; c_pc_load = 1'b0; ack_force = 1'b0;
    checks++;
    if ({instr_valid, imem_req, pc, opcode, ra, imm} !== {2'b10, 8'h01, 4'h0, 4'h1, 8'h10}) begin
      errors++; $display("FAIL ignored: got v%b req%b pc%h op%h ra%h imm%h exp v1 req0 pc01 op0 ra1 imm10",
                         instr_valid, imem_req, pc, opcode, ra, imm);
    end
    mem[1] = 16'h0110;
  endtask

  task automatic test_hold();
    pulse(1'b0, 1'b0);
    checks++;
    if ({instr_valid, imem_req, imem_addr} !== {2'b01, 8'h01}) begin
      errors++; $display("FAIL hold_fetch: got v%b req%b addr %h exp v0 req1 addr 01", instr_valid, imem_req, imem_addr);
    end
    step();
    checks++;
    if ({instr_valid, pc} !== {1'b1, 8'h01}) begin
      errors++; $display("FAIL hold_issue: got v%b pc%h exp v1 pc01", instr_valid, pc);
    end
  endtask

  task automatic test_wrap();
    mem[8'h10] = 16'hB0FF;
    mem[8'hFF] = 16'h3000;
    mem[8'h00] = 16'h9140;
    pulse(1'b0, 1'b1);                       // imm 0x10
    checks++;
    if (imem_addr !== 8'h10) begin
      errors++; $display("FAIL load_addr: got %h exp 10", imem_addr);
    end
    step();
    pulse(1'b0, 1'b1);                       // imm 0xFF
    step();
    checks++;
    if ({instr_valid, pc, opcode} !== {1'b1, 8'hFF, 4'h3}) begin
      errors++; $display("FAIL at_ff: got v%b pc%h op%h exp v1 pcFF op3", instr_valid, pc, opcode);
    end
    pulse(1'b1, 1'b0);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL wrap_addr: got req%b addr %h exp req1 addr 00", imem_req, imem_addr);
    end
    step();
    checks++;
    if ({pc, imm} !== {8'h00, 8'h40}) begin
      errors++; $display("FAIL wrap_issue: got pc%h imm%h exp pc00 imm40", pc, imm);
    end
    pulse(1'b1, 1'b1);                       // load wins over inc
    checks++;
    if (imem_addr !== 8'h40) begin
      errors++; $display("FAIL load_wins: got addr %h exp 40", imem_addr);
    end
    step();
  endtask

  task automatic test_wait();
    mem[8'h41] = 16'h5678;
    wait_n = 3;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 8'h41, 1'b0}) begin
        errors++; $display("FAIL wait_cyc%0d: got req%b addr%h v%b exp req1 addr41 v0", i, imem_req, imem_addr, instr_valid);
      end
      step();
    end
    checks++;
    if ({instr_valid, pc, opcode, ra} !== {1'b1, 8'h41, 4'h5, 4'h6}) begin
      errors++; $display("FAIL wait_issue: got v%b pc%h op%h ra%h exp v1 pc41 op5 ra6", instr_valid, pc, opcode, ra);
    end
    wait_n = 0;
  endtask

  task automatic test_reset_mid();
    wait_n = 5;
    pulse(1'b1, 1'b0);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h42}) begin
      errors++; $display("FAIL mid_req: got req%b addr%h exp req1 addr42", imem_req, imem_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, instr_valid, imem_addr, pc, opcode, imm} !== 30'h0) begin
      errors++; $display("FAIL mid_reset: got req%b v%b addr%h pc%h op%h imm%h exp all 0",
                         imem_req, instr_valid, imem_addr, pc, opcode, imm);
    end
    wait_n = 0; mem[0] = 16'h2A05; ack_force = 1'b1;
    step(); step();
    ack_force = 1'b0;
    checks++;
    if ({imem_req, instr_valid, opcode} !== 6'h0) begin
      errors++; $display("FAIL ack_in_reset: got req%b v%b op%h exp 0 0 0", imem_req, instr_valid, opcode);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, 8'h00}) begin
      errors++; $display("FAIL rerelease_req: got req%b v%b addr%h exp 1 0 00", imem_req, instr_valid, imem_addr);
    end
    step();
    checks++;
    if ({instr_valid, pc, opcode} !== {1'b1, 8'h00, 4'h2}) begin
      errors++; $display("FAIL rerelease_issue: got v%b pc%h op%h exp v1 pc00 op2", instr_valid, pc, opcode);
    end
  endtask
`else
  task automatic test_pf_seq();
    logic [15:0] w;
    hold_reset();
    mem[0] = 16'h2A05; mem[1] = 16'h0110; mem[2] = 16'h1220;
    mem[3] = 16'h3330; mem[4] = 16'h4440;
    wait_n = 0;
    rst_n = 1'b1;
    step();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL pf_first_req: got req%b addr%h exp req1 addr00", imem_req, imem_addr);
    end
    step();
    checks++;
    if ({instr_valid, pc, opcode} !== {1'b1, 8'h00, 4'h2}) begin
      errors++; $display("FAIL pf_first_issue: got v%b pc%h op%h exp v1 pc00 op2", instr_valid, pc, opcode);
    end
    step();
    checks++;
    if ({instr_valid, imem_req, imem_addr} !== {2'b11, 8'h01}) begin
      errors++; $display("FAIL pf_prefetch: got v%b req%b addr%h exp v1 req1 addr01", instr_valid, imem_req, imem_addr);
    end
    step();
    exec_done = 1'b1; c_pc_inc = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      w = mem[i];
      checks++;
      if ({instr_valid, pc, opcode, ra, rb, imm} !== {1'b1, 8'(i), w[15:12], w[11:8], w[7:4], w[7:0]}) begin
        errors++; $display("FAIL pf_b2b%0d: got v%b pc%h op%h ra%h imm%h exp v1 pc%h op%h ra%h imm%h",
                           i, instr_valid, pc, opcode, ra, imm, 8'(i), w[15:12], w[11:8], w[7:0]);
      end
    end
    exec_done = 1'b0; c_pc_inc = 1'b0;
  endtask

  task automatic test_pf_jump();
    int  n;
    logic stale;
    hold_reset();
    mem[0] = 16'hB010; mem[1] = 16'h1111; mem[8'h10] = 16'hC0AB;
    wait_n = 2;
    rst_n = 1'b1;
    for (n = 0; n < 20 && instr_valid !== 1'b1; n++) step();
    checks++;
    if ({instr_valid, pc, opcode, imm} !== {1'b1, 8'h00, 4'hB, 8'h10}) begin
      errors++; $display("FAIL pfj_issue: got v%b pc%h op%h imm%h exp v1 pc00 opB imm10", instr_valid, pc, opcode, imm);
    end
    step();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h01}) begin
      errors++; $display("FAIL pfj_prefetch: got req%b addr%h exp req1 addr01", imem_req, imem_addr);
    end
    pulse(1'b0, 1'b1);
    checks++;
    if ({instr_valid, imem_req, imem_addr} !== {2'b01, 8'h01}) begin
      errors++; $display("FAIL pfj_drain: got v%b req%b addr%h exp v0 req1 addr01", instr_valid, imem_req, imem_addr);
    end
    stale = 1'b0;
    for (n = 0; n < 30 && instr_valid !== 1'b1; n++) begin
      step();
      if (instr_valid === 1'b1 && opcode === 4'h1) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin
      errors++; $display("FAIL pfj_stale: got stale word issued %b exp 0", stale);
    end
    checks++;
    if ({instr_valid, pc, opcode, imm} !== {1'b1, 8'h10, 4'hC, 8'hAB}) begin
      errors++; $display("FAIL pfj_target: got v%b pc%h op%h imm%h exp v1 pc10 opC immAB", instr_valid, pc, opcode, imm);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef INSTR_FETCH_PREFETCH_EN
    test_first_fetch();
    test_inc();
    test_ignored();
    test_hold();
    test_wrap();
    test_wait();
    test_reset_mid();
`else
    test_pf_seq();
    test_pf_jump();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1);
  end

endmodule
